// File: rtl/md_unit_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: md_op encodings,
// default latencies, MIPS funct codes and small decode helpers.
package md_unit_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1a;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_result_t;

   // Ops that occupy the unit for several cycles
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_ctrl_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including
// the divide-by-zero and signed-overflow corner cases.
module md_calc
   import md_unit_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] hi_res,
   output logic [31:0] lo_res
);

   logic signed [63:0] rs_ext;
   logic signed [63:0] rt_ext;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic        [31:0] rt_sdiv;
   logic        [31:0] rt_udiv;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;
   md_result_t         res;

   assign rs_ext   = {{32{rs[31]}}, rs};
   assign rt_ext   = {{32{rt[31]}}, rt};
   assign prod_s   = rs_ext * rt_ext;
   assign prod_u   = {32'd0, rs} * {32'd0, rt};

   assign div_zero = (rt == 32'd0);
   assign div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

   // Divisors are forced to 1 in the special cases so the dividers never see them
   assign rt_sdiv  = (div_zero || div_ovf) ? 32'd1 : rt;
   assign rt_udiv  = div_zero ? 32'd1 : rt;
   assign quot_s   = $signed(rs) / $signed(rt_sdiv);
   assign rem_s    = $signed(rs) % $signed(rt_sdiv);
   assign quot_u   = rs / rt_udiv;
   assign rem_u    = rs % rt_udiv;

   always_comb begin
      res = '0;
      case (op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV: begin
            if (div_zero) begin
               res.hi = rs;
               res.lo = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               res.hi = 32'd0;
               res.lo = 32'h8000_0000;
            end else begin
               res.hi = rem_s;
               res.lo = quot_s;
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               res.hi = rs;
               res.lo = 32'hFFFF_FFFF;
            end else begin
               res.hi = rem_u;
               res.lo = quot_u;
            end
         end
         default: res = '0;
      endcase
   end

   assign hi_res = res.hi;
   assign lo_res = res.lo;

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO for the MIPS pipeline.
// Define MD_DIV0_FAST_EN to retire div/divu by zero immediately, leaving HI/LO untouched.
module md_unit_ctrl
   import md_unit_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  E_md_op,
   input  logic        E_md_start,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        E_mf_sel,
   input  logic        D_md_use,
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] md_rdata,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [4:0]  cnt;
   logic [0:0]  state;
   logic [31:0] hi_shadow;
   logic [31:0] lo_shadow;
   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        e_arith;
   logic        skip_div0;

   md_calc u_calc (
      .op     (E_md_op),
      .rs     (E_rs_data),
      .rt     (E_rt_data),
      .hi_res (calc_hi),
      .lo_res (calc_lo)
   );

   assign state   = (cnt != 5'd0) ? ST_BUSY : ST_IDLE;
   assign md_busy = (state == ST_BUSY);
   assign e_arith = E_md_start & md_is_arith(E_md_op);

`ifdef MD_DIV0_FAST_EN
   assign skip_div0 = md_is_div(E_md_op) & (E_rt_data == 32'd0);
`else
   assign skip_div0 = 1'b0;
`endif

   // The E-stage term holds a dependent D instruction in the very cycle the op issues
   assign md_stall = D_md_use & (md_busy | e_arith);
   assign md_rdata = E_mf_sel ? hi_q : lo_q;

   // Starts are only honoured when idle; HI/LO commit on the last busy edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 5'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         hi_shadow <= 32'd0;
         lo_shadow <= 32'd0;
      end else if (state == ST_BUSY) begin
         cnt <= cnt - 5'd1;
         if (cnt == 5'd1) begin
            hi_q <= hi_shadow;
            lo_q <= lo_shadow;
         end
      end else if (E_md_start) begin
         if (e_arith) begin
            if (!skip_div0) begin
               hi_shadow <= calc_hi;
               lo_shadow <= calc_lo;
               cnt       <= md_is_div(E_md_op) ? DIV_CNT : MULT_CNT;
            end
         end else if (E_md_op == MD_MTHI) begin
            hi_q <= E_rs_data;
         end else if (E_md_op == MD_MTLO) begin
            lo_q <= E_rs_data;
         end
      end
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed test-plan scenarios followed
// by randomized traffic, all checked against an arithmetic reference model.
module tb_md_unit_ctrl;
   import md_unit_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  E_md_op = 3'd0;
   logic        E_md_start = 1'b0;
   logic [31:0] E_rs_data = 32'd0;
   logic [31:0] E_rt_data = 32'd0;
   logic        E_mf_sel = 1'b0;
   logic        D_md_use = 1'b0;
   logic        md_busy;
   logic        md_stall;
   logic [31:0] md_rdata;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   md_unit_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .E_md_op    (E_md_op),
      .E_md_start (E_md_start),
      .E_rs_data  (E_rs_data),
      .E_rt_data  (E_rt_data),
      .E_mf_sel   (E_mf_sel),
      .D_md_use   (D_md_use),
      .md_busy    (md_busy),
      .md_stall   (md_stall),
      .md_rdata   (md_rdata),
      .hi_q       (hi_q),
      .lo_q       (lo_q)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // Reference arithmetic in 64-bit integers, returns {HI, LO}
   function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      longint sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(rs));
      sb = longint'($signed(rt));
      ua = {32'd0, rs};
      ub = {32'd0, rt};
      case (op)
         3'd1: begin sq = sa * sb; return sq; end
         3'd2: begin uq = ua * ub; return uq; end
         3'd3: begin
            if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         3'd4: begin
            if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Model: a start at edge e is pending until edge e+N, when HI/LO commit
   int          edge_no = 0;
   int          m_ready_at = 0;
   logic        m_pend = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] m_res = 64'd0;

   always @(posedge clk) begin
      edge_no++;
      if (rst) begin
         m_pend = 1'b0;
         m_hi   = 32'd0;
         m_lo   = 32'd0;
      end else if (m_pend) begin
         if (edge_no == m_ready_at) begin
            m_hi   = m_res[63:32];
            m_lo   = m_res[31:0];
            m_pend = 1'b0;
         end
      end else if (E_md_start) begin
         if (E_md_op == 3'd1 || E_md_op == 3'd2) begin
            m_res      = refResult(E_md_op, E_rs_data, E_rt_data);
            m_ready_at = edge_no + 5;
            m_pend     = 1'b1;
         end else if (E_md_op == 3'd3 || E_md_op == 3'd4) begin
`ifdef MD_DIV0_FAST_EN
            if (E_rt_data != 32'd0) begin
               m_res      = refResult(E_md_op, E_rs_data, E_rt_data);
               m_ready_at = edge_no + 10;
               m_pend     = 1'b1;
            end
`else
            m_res      = refResult(E_md_op, E_rs_data, E_rt_data);
            m_ready_at = edge_no + 10;
            m_pend     = 1'b1;
`endif
         end else if (E_md_op == 3'd5) begin
            m_hi = E_rs_data;
         end else if (E_md_op == 3'd6) begin
            m_lo = E_rs_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_stall;
         exp_stall = D_md_use & (m_pend | (E_md_start & (E_md_op >= 3'd1) & (E_md_op <= 3'd4)));
         checkOutput("md_busy", 32'(md_busy), 32'(m_pend));
         checkOutput("md_stall", 32'(md_stall), 32'(exp_stall));
         checkOutput("hi_q", hi_q, m_hi);
         checkOutput("lo_q", lo_q, m_lo);
         checkOutput("md_rdata", md_rdata, E_mf_sel ? m_hi : m_lo);
      end
   end

   task automatic applyStimulus(input logic r, input logic [2:0] op, input logic st,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic use_d, input logic sel);
      @(posedge clk);
      #1;
      rst        = r;
      E_md_op    = op;
      E_md_start = st;
      E_rs_data  = rs;
      E_rt_data  = rt;
      D_md_use   = use_d;
      E_mf_sel   = sel;
   endtask

   // Counts busy cycles until md_busy drops; returns at the negedge where it is low
   task automatic waitIdle(output int n);
      n = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!md_busy) return;
         n++;
      end
      total++;
      bad++;
      $display("[TB] FAIL wait_idle: got=busy want=idle within 64 cycles");
   endtask

   task automatic runArith(input string name, input logic [2:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int exp_cycles,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      applyStimulus(1'b0, op, 1'b1, rs, rt, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
      waitIdle(n);
      checkOutput({name, "_cycles"}, n, exp_cycles);
      checkOutput({name, "_hi"}, hi_q, exp_hi);
      checkOutput({name, "_lo"}, lo_q, exp_lo);
      checkOutput({name, "_rdata"}, md_rdata, exp_hi);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      checkOutput("reset_hi", hi_q, 32'd0);
      checkOutput("reset_lo", lo_q, 32'd0);
      checkOutput("reset_busy", 32'(md_busy), 32'd0);

      runArith("mult",  3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      runArith("multu", 3'd2, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB);
      runArith("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runArith("divu",  3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      runArith("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      // Stall held across a divide, then a released mflo sees the new LO
      applyStimulus(1'b0, 3'd3, 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stall_start", 32'(md_stall), 32'd1);
      applyStimulus(1'b0, 3'd0, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
      waitIdle(n);
      checkOutput("stall_cycles", n, 10);
      checkOutput("stall_after", 32'(md_stall), 32'd0);
      checkOutput("mflo_after", md_rdata, 32'hFFFF_FFF2);

      applyStimulus(1'b0, 3'd5, 1'b1, 32'h1234_5678, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("mthi_stall", 32'(md_stall), 32'd0);
      applyStimulus(1'b0, 3'd6, 1'b1, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("mthi_hi", hi_q, 32'h1234_5678);
      checkOutput("mtlo_stall", 32'(md_stall), 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mtlo_lo", lo_q, 32'h9ABC_DEF0);
      checkOutput("mt_busy", 32'(md_busy), 32'd0);

`ifdef MD_DIV0_FAST_EN
      runArith("div0", 3'd3, 32'd5, 32'd0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
`else
      runArith("div0", 3'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
`endif

      // Reset lands in the third busy cycle of a mult
      applyStimulus(1'b0, 3'd1, 1'b1, 32'd3, 32'd5, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst_busy", 32'(md_busy), 32'd0);
      checkOutput("rst_hi", hi_q, 32'd0);
      checkOutput("rst_lo", lo_q, 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("rst_late_hi", hi_q, 32'd0);
      checkOutput("rst_late_lo", lo_q, 32'd0);

      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom_range(0, 149) == 0),
                       3'($urandom_range(0, 7)),
                       ($urandom_range(0, 2) == 0),
                       pickOperand(), pickOperand(),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      waitIdle(n);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
